// File: rtl/msdf_sd_pkg.sv
// Shared definitions for the MSDF operand transmitter: signed-digit
// encodings, FSM state encodings and the per-digit encoder.
package msdf_sd_pkg;

  localparam logic [1:0] SD_ZERO = 2'b00;
  localparam logic [1:0] SD_POS  = 2'b10;
  localparam logic [1:0] SD_NEG  = 2'b01;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_TAIL = 2'd2
  } state_t;

  // Map one magnitude bit plus the operand sign onto a radix-2 signed digit.
  function automatic logic [1:0] sd_encode(input logic mag_bit, input logic sign);
    logic [1:0] d;
    d = SD_ZERO;
    if (mag_bit) d = sign ? SD_NEG : SD_POS;
    return d;
  endfunction

endpackage

// File: rtl/msdf_sd_serializer.sv
// One operand lane: converts a two's-complement fraction to sign-magnitude
// on load and presents its magnitude bits MSB-first as signed digits.
module msdf_sd_serializer
  import msdf_sd_pkg::*;
#(
  parameter int FRAC_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  shift,
  input  logic [FRAC_WIDTH:0]   op,
  output logic [1:0]            digit,
  output logic                  sat
);

  localparam logic [FRAC_WIDTH:0] NEG_ONE = {1'b1, {FRAC_WIDTH{1'b0}}};

  logic [FRAC_WIDTH-1:0] op_frac;
  logic [FRAC_WIDTH-1:0] mag_in;
  logic [FRAC_WIDTH-1:0] sreg;
  logic                  sign_q;

  assign op_frac = op[FRAC_WIDTH-1:0];

  // Magnitude of the operand; -1.0 has no FRAC_WIDTH-bit magnitude so it clamps to all ones.
  always_comb begin
    mag_in = op_frac;
    if (op == NEG_ONE) mag_in = '1;
    else if (op[FRAC_WIDTH]) mag_in = -op_frac;
  end

  // Capture sign/magnitude/saturation on load, then shift one magnitude bit out per accepted digit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sreg   <= '0;
      sign_q <= 1'b0;
      sat    <= 1'b0;
    end else if (load) begin
      sreg   <= mag_in;
      sign_q <= op[FRAC_WIDTH];
      sat    <= (op == NEG_ONE);
    end else if (shift) begin
      sreg <= {sreg[FRAC_WIDTH-2:0], 1'b0};
    end
  end

  assign digit = sd_encode(sreg[FRAC_WIDTH-1], sign_q);

endmodule

// File: rtl/msdf_operand_tx.sv
// MSDF multiply write-channel transmitter: streams (x, y) signed-digit pairs
// MSB-first with valid/ready/last, followed by zero pairs that flush the
// downstream online delay.
module msdf_operand_tx
  import msdf_sd_pkg::*;
#(
  parameter int FRAC_WIDTH = 16,
  parameter int DATA_WIDTH = 2,
  parameter int TAIL_ZEROS = 3,
  parameter int LEN_WIDTH  = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_start,
  input  logic [FRAC_WIDTH:0]   i_op_x,
  input  logic [FRAC_WIDTH:0]   i_op_y,
  input  logic [LEN_WIDTH-1:0]  i_len,
  output logic                  o_busy,
  output logic                  o_done,
  output logic                  o_sat_x,
  output logic                  o_sat_y,
  output logic                  o_mbus_wen,
  output logic [DATA_WIDTH-1:0] o_mbus_wdata_x,
  output logic [DATA_WIDTH-1:0] o_mbus_wdata_y,
  output logic                  o_mbus_wvalid,
  output logic                  o_mbus_wlast,
  input  logic                  i_mbus_wready
);

  localparam int CNT_W = $clog2(FRAC_WIDTH + TAIL_ZEROS + 1);
  localparam logic [LEN_WIDTH-1:0] FULL_LEN  = LEN_WIDTH'(FRAC_WIDTH);
  localparam logic [CNT_W-1:0]     TAIL_LAST = CNT_W'((TAIL_ZEROS > 0) ? TAIL_ZEROS - 1 : 0);

  state_t               state;
  logic [CNT_W-1:0]     cnt;
  logic [LEN_WIDTH-1:0] len_sel;
  logic [CNT_W-1:0]     len_m1;
  logic                 beat;
  logic                 load;
  logic                 shift;
  logic [1:0]           digit_x;
  logic [1:0]           digit_y;

  // Zero or oversize lengths fall back to the full fraction width.
  always_comb begin
    len_sel = i_len;
    if (i_len == '0 || i_len > FULL_LEN) len_sel = FULL_LEN;
  end

  assign len_m1 = CNT_W'(len_sel - LEN_WIDTH'(1));
  assign beat   = o_mbus_wvalid & i_mbus_wready;
  assign load   = (state == ST_IDLE) & i_start;
  assign shift  = (state == ST_SEND) & beat;

  msdf_sd_serializer #(.FRAC_WIDTH(FRAC_WIDTH)) u_ser_x (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .op    (i_op_x),
    .digit (digit_x),
    .sat   (o_sat_x)
  );

  msdf_sd_serializer #(.FRAC_WIDTH(FRAC_WIDTH)) u_ser_y (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .op    (i_op_y),
    .digit (digit_y),
    .sat   (o_sat_y)
  );

  // Frame sequencer: counts remaining beats of the current phase and precomputes wlast for the next beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= ST_IDLE;
      cnt           <= '0;
      o_mbus_wvalid <= 1'b0;
      o_mbus_wlast  <= 1'b0;
      o_busy        <= 1'b0;
      o_done        <= 1'b0;
    end else begin
      o_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (i_start) begin
            state         <= ST_SEND;
            cnt           <= len_m1;
            o_mbus_wvalid <= 1'b1;
            o_busy        <= 1'b1;
            o_mbus_wlast  <= (TAIL_ZEROS == 0) && (len_m1 == '0);
          end
        end
        ST_SEND: begin
          if (beat) begin
            if (cnt == '0) begin
              if (TAIL_ZEROS == 0) begin
                state         <= ST_IDLE;
                o_mbus_wvalid <= 1'b0;
                o_mbus_wlast  <= 1'b0;
                o_busy        <= 1'b0;
                o_done        <= 1'b1;
              end else begin
                state        <= ST_TAIL;
                cnt          <= TAIL_LAST;
                o_mbus_wlast <= (TAIL_ZEROS == 1);
              end
            end else begin
              cnt          <= cnt - CNT_W'(1);
              o_mbus_wlast <= (TAIL_ZEROS == 0) && (cnt == CNT_W'(1));
            end
          end
        end
        ST_TAIL: begin
          if (beat) begin
            if (cnt == '0) begin
              state         <= ST_IDLE;
              o_mbus_wvalid <= 1'b0;
              o_mbus_wlast  <= 1'b0;
              o_busy        <= 1'b0;
              o_done        <= 1'b1;
            end else begin
              cnt          <= cnt - CNT_W'(1);
              o_mbus_wlast <= (cnt == CNT_W'(1));
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign o_mbus_wen     = o_mbus_wvalid;
  assign o_mbus_wdata_x = DATA_WIDTH'((state == ST_SEND) ? digit_x : SD_ZERO);
  assign o_mbus_wdata_y = DATA_WIDTH'((state == ST_SEND) ? digit_y : SD_ZERO);

endmodule

// File: tb/tb_msdf_operand_tx.sv
// Scoreboard bench for msdf_operand_tx: instance a uses TAIL_ZEROS=3,
// instance b uses TAIL_ZEROS=0; both FRAC_WIDTH=8.
`timescale 1ns/1ps
module tb_msdf_operand_tx;

  localparam int FW = 8;
  localparam int LW = 8;

  typedef struct packed {
    logic [1:0] x;
    logic [1:0] y;
    logic       last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  logic          start_a = 1'b0, ready_a = 1'b1;
  logic [FW:0]   x_a = '0, y_a = '0;
  logic [LW-1:0] len_a = '0;
  logic          busy_a, done_a, satx_a, saty_a, wen_a, valid_a, last_a;
  logic [1:0]    wx_a, wy_a;

  logic          start_b = 1'b0, ready_b = 1'b1;
  logic [FW:0]   x_b = '0, y_b = '0;
  logic [LW-1:0] len_b = '0;
  logic          busy_b, done_b, satx_b, saty_b, wen_b, valid_b, last_b;
  logic [1:0]    wx_b, wy_b;

  beat_t q_a[$];
  beat_t q_b[$];
  logic  pend_a = 1'b0, pend_b = 1'b0;
  int    valid_cycles_a = 0;
  int    vec_count = 0;
  int    err_count = 0;

  msdf_operand_tx #(.FRAC_WIDTH(FW), .DATA_WIDTH(2), .TAIL_ZEROS(3), .LEN_WIDTH(LW)) dut_a (
    .clk(clk), .rst(rst), .i_start(start_a), .i_op_x(x_a), .i_op_y(y_a), .i_len(len_a),
    .o_busy(busy_a), .o_done(done_a), .o_sat_x(satx_a), .o_sat_y(saty_a),
    .o_mbus_wen(wen_a), .o_mbus_wdata_x(wx_a), .o_mbus_wdata_y(wy_a),
    .o_mbus_wvalid(valid_a), .o_mbus_wlast(last_a), .i_mbus_wready(ready_a)
  );

  msdf_operand_tx #(.FRAC_WIDTH(FW), .DATA_WIDTH(2), .TAIL_ZEROS(0), .LEN_WIDTH(LW)) dut_b (
    .clk(clk), .rst(rst), .i_start(start_b), .i_op_x(x_b), .i_op_y(y_b), .i_len(len_b),
    .o_busy(busy_b), .o_done(done_b), .o_sat_x(satx_b), .o_sat_y(saty_b),
    .o_mbus_wen(wen_b), .o_mbus_wdata_x(wx_b), .o_mbus_wdata_y(wy_b),
    .o_mbus_wvalid(valid_b), .o_mbus_wlast(last_b), .i_mbus_wready(ready_b)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vec_count++;
    if (act !== exp) begin
      err_count++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Push the expected beats of one frame: n operand digit pairs (first digit in the top bits) then tz zero pairs.
  task automatic expectFrame(input int dut, input int n, input logic [31:0] xs,
                             input logic [31:0] ys, input int tz);
    beat_t b;
    for (int i = 0; i < n; i++) begin
      b.x    = xs[2*(n-1-i) +: 2];
      b.y    = ys[2*(n-1-i) +: 2];
      b.last = (tz == 0) && (i == n - 1);
      if (dut == 0) q_a.push_back(b); else q_b.push_back(b);
    end
    for (int i = 0; i < tz; i++) begin
      b.x    = 2'b00;
      b.y    = 2'b00;
      b.last = (i == tz - 1);
      if (dut == 0) q_a.push_back(b); else q_b.push_back(b);
    end
  endtask

  // Queue the expected frame for instance a and pulse its start; returns with beat 1 presented.
  task automatic applyStimulus(input logic [FW:0] x, input logic [FW:0] y, input logic [LW-1:0] len,
                               input int n, input logic [31:0] xs, input logic [31:0] ys);
    expectFrame(0, n, xs, ys, 3);
    @(posedge clk); #1;
    x_a = x; y_a = y; len_a = len; start_a = 1'b1;
    @(posedge clk); #1;
    start_a = 1'b0;
  endtask

  // Wait (bounded) until every expected beat and done pulse has been observed.
  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((q_a.size() != 0 || q_b.size() != 0 || pend_a || pend_b) && n < budget) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain_left", 32'(q_a.size() + q_b.size()), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Monitor: compare presented beats with the queue heads; pop on handshake; check done timing.
  always @(negedge clk) begin
    beat_t e;
    if (rst) begin
      pend_a = 1'b0;
      pend_b = 1'b0;
    end else begin
      checkOutput("done_a", done_a, pend_a);
      pend_a = 1'b0;
      checkOutput("wen_a", wen_a, valid_a);
      if (valid_a) begin
        valid_cycles_a++;
        if (q_a.size() == 0) checkOutput("unexpected_beat_a", valid_a, 0);
        else begin
          e = q_a[0];
          checkOutput("wdata_x_a", wx_a, e.x);
          checkOutput("wdata_y_a", wy_a, e.y);
          checkOutput("wlast_a", last_a, e.last);
          if (ready_a) begin
            void'(q_a.pop_front());
            pend_a = e.last;
          end
        end
      end
      checkOutput("done_b", done_b, pend_b);
      pend_b = 1'b0;
      if (valid_b) begin
        if (q_b.size() == 0) checkOutput("unexpected_beat_b", valid_b, 0);
        else begin
          e = q_b[0];
          checkOutput("wdata_x_b", wx_b, e.x);
          checkOutput("wdata_y_b", wy_b, e.y);
          checkOutput("wlast_b", last_b, e.last);
          if (ready_b) begin
            void'(q_b.pop_front());
            pend_b = e.last;
          end
        end
      end
    end
  end

  // Safety net so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  // Directed scenarios.
  initial begin
    $display("[TB] start");
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_valid", valid_a, 0);
    checkOutput("rst_busy", busy_a, 0);
    checkOutput("rst_last", last_a, 0);
    checkOutput("rst_wdata", {wx_a, wy_a}, 0);
    checkOutput("rst_sat", {satx_a, saty_a}, 0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // 1: +0.5 / -0.25, full length
    checkOutput("idle_valid", valid_a, 0);
    applyStimulus(9'b0_1000_0000, 9'b1_1100_0000, 8'd0, 8, 32'h8000, 32'h1000);
    checkOutput("first_valid", valid_a, 1);
    checkOutput("first_busy", busy_a, 1);
    waitDrain(100);
    checkOutput("t1_busy", busy_a, 0);
    checkOutput("t1_sat", {satx_a, saty_a}, 0);

    // 2: -1.0 saturates
    applyStimulus(9'b1_0000_0000, 9'b0_0000_0000, 8'd0, 8, 32'h5555, 32'h0000);
    waitDrain(100);
    checkOutput("t2_sat_x", satx_a, 1);
    checkOutput("t2_sat_y", saty_a, 0);

    // 3: stall while beat 2 is presented
    valid_cycles_a = 0;
    applyStimulus(9'b0_1000_0000, 9'b1_1100_0000, 8'd0, 8, 32'h8000, 32'h1000);
    @(posedge clk); #1;
    ready_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    ready_a = 1'b1;
    waitDrain(100);
    checkOutput("t3_valid_cycles", 32'(valid_cycles_a), 14);
    checkOutput("t3_sat_x", satx_a, 0);

    // 4: short length
    applyStimulus(9'b0_1011_0000, 9'b0_0000_0000, 8'd4, 4, 32'h008A, 32'h0000);
    waitDrain(100);

    // 5: asynchronous reset during beat 5
    applyStimulus(9'b0_1000_0000, 9'b1_1100_0000, 8'd0, 8, 32'h8000, 32'h1000);
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    checkOutput("t5_valid", valid_a, 0);
    checkOutput("t5_last", last_a, 0);
    checkOutput("t5_busy", busy_a, 0);
    q_a.delete();
    repeat (2) @(posedge clk);
    #1;
    checkOutput("t5_done", done_a, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(9'b0_1000_0000, 9'b1_1100_0000, 8'd0, 8, 32'h8000, 32'h1000);
    waitDrain(100);

    // 6: no tail, start held high across two frames
    expectFrame(1, 3, 32'h22, 32'h11, 0);
    expectFrame(1, 3, 32'h22, 32'h11, 0);
    @(posedge clk); #1;
    x_b = 9'b0_1010_0000; y_b = 9'b1_0110_0000; len_b = 8'd3; start_b = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checkOutput("t6_gap_valid", valid_b, 0);
    checkOutput("t6_gap_done", done_b, 1);
    checkOutput("t6_gap_busy", busy_b, 0);
    @(posedge clk); #1;
    checkOutput("t6_restart_valid", valid_b, 1);
    start_b = 1'b0;
    waitDrain(100);
    checkOutput("t6_busy", busy_b, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
